ram_port_arbiter: RTL and testbench

- Shares one port of the dual-port data RAM between two requesters: m0 (CPU load/store unit) and m1 (display/DMA fetch engine).
- Arbitration is round-robin, with an optional locked burst so m1 can stream sequential reads without interleaving.
- Sits between the requesters and the RAM's port-B signals (addr, data, we, q); the RAM's read data is registered with 1-cycle latency.

---
 rtl/ram_port_arbiter_pkg.sv | 6 +
 rtl/ram_port_arbiter_if.sv | 32 +++
 rtl/ram_port_arbiter_rr_pick2.sv | 12 +
 rtl/ram_port_arbiter.sv | 78 +++++++
 tb/tb_ram_port_arbiter.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// ram_arb_pkg: shared state encoding and requester ids for the RAM port arbiter.
package ram_arb_pkg;
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
    localparam logic REQ_M0 = 1'b0;
    localparam logic REQ_M1 = 1'b1;
endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: requester handshakes plus RAM port-B signals for the arbiter.
interface ram_port_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
);
    logic                  m0_req, m1_req;
    logic                  m0_we, m1_we;
    logic                  m0_lock, m1_lock;
    logic [ADDR_WIDTH-1:0] m0_addr, m1_addr;
    logic [DATA_WIDTH-1:0] m0_wdata, m1_wdata;
    logic                  m0_gnt, m1_gnt;
    logic                  m0_rvalid, m1_rvalid;
    logic [DATA_WIDTH-1:0] m0_rdata, m1_rdata;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_data;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_q;

    modport master (
        output m0_req, m1_req, m0_we, m1_we, m0_lock, m1_lock,
        output m0_addr, m1_addr, m0_wdata, m1_wdata, ram_q,
        input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
        input  ram_addr, ram_data, ram_we
    );

    modport slave (
        input  m0_req, m1_req, m0_we, m1_we, m0_lock, m1_lock,
        input  m0_addr, m1_addr, m0_wdata, m1_wdata, ram_q,
        output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
        output ram_addr, ram_data, ram_we
    );
endinterface

// File: rtl/ram_port_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin chooser; on a tie the requester that was not last wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic [1:0] mask,
    output logic [1:0] gnt
);
    logic [1:0] elig;

    assign elig = req & mask;
    assign gnt  = &elig ? (last ? 2'b01 : 2'b10) : elig;
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one RAM port between m0 and m1 with round-robin and locked bursts.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_BURST  = 8
) (
    input logic           clk,
    input logic           reset,
    ram_port_arbiter_if.slave bus
);
    localparam int CW = $clog2(MAX_BURST + 1);

    state_t                state;
    logic                  last;
    logic [CW-1:0]         burst_cnt;
    logic [1:0]            pend, req, lock, we, mask, pick, gnt, rvalid;
    logic                  own_hit, burst_end, gid;
    logic [ADDR_WIDTH-1:0] addr_sel;
    logic [DATA_WIDTH-1:0] data_sel;

    assign req  = {bus.m1_req, bus.m0_req};
    assign lock = {bus.m1_lock, bus.m0_lock};
    assign we   = {bus.m1_we, bus.m0_we};

    // The owner is masked in alone only while it is still requesting.
    assign own_hit = (state == OWN0 && req[REQ_M0]) || (state == OWN1 && req[REQ_M1]);
    assign mask    = own_hit ? (state == OWN1 ? 2'b10 : 2'b01) : 2'b11;

    rr_pick2 u_pick (
        .req  (req),
        .last (last),
        .mask (mask),
        .gnt  (pick)
    );

    assign gnt       = reset ? 2'b00 : pick;
    assign gid       = gnt[REQ_M1];
    assign burst_end = !lock[gid] || (burst_cnt + CW'(1)) == CW'(MAX_BURST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            burst_cnt <= '0;
            pend      <= '0;
        end else begin
            pend <= gnt & ~we;
            if (|gnt) last <= gid;
            if (own_hit) begin
                burst_cnt <= burst_cnt + CW'(1);
                if (burst_end) state <= IDLE;
            end else if (state == IDLE && |gnt && lock[gid] && MAX_BURST > 1) begin
                state     <= gid ? OWN1 : OWN0;
                burst_cnt <= CW'(1);
            end else begin
                state     <= IDLE;
                burst_cnt <= '0;
            end
        end
    end

    assign addr_sel     = gnt[REQ_M1] ? bus.m1_addr : bus.m0_addr;
    assign data_sel     = gnt[REQ_M1] ? bus.m1_wdata : bus.m0_wdata;
    assign bus.ram_addr = addr_sel;
    assign bus.ram_data = data_sel;
    assign bus.ram_we   = |(gnt & we);
    assign bus.m0_gnt   = gnt[REQ_M0];
    assign bus.m1_gnt   = gnt[REQ_M1];

    // A reset arriving while a read is outstanding suppresses its return.
    assign rvalid        = pend & {2{~reset}};
    assign bus.m0_rvalid = rvalid[REQ_M0];
    assign bus.m1_rvalid = rvalid[REQ_M1];
    assign bus.m0_rdata  = rvalid[REQ_M0] ? bus.ram_q : '0;
    assign bus.m1_rdata  = rvalid[REQ_M1] ? bus.ram_q : '0;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed plan plus random traffic against a rule-level arbiter model.
module tb_ram_port_arbiter;
    localparam int DW = 16;
    localparam int AW = 10;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [DW-1:0] mem [1<<AW];
    logic [DW-1:0] ref_mem [1<<AW];

    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_data;
        bus.ram_q <= mem[bus.ram_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference state: who owns a burst (-1 none), grants so far, last winner, pending reads.
    int            own = -1;
    int            cnt = 0;
    bit            mlast = 1'b1;
    bit            pv [2];
    logic [DW-1:0] pd [2];

    bit            rq [2], wq [2], lq [2];
    logic [AW-1:0] aq [2];
    logic [DW-1:0] dq [2];

    task automatic set_m(input int i, input bit r, input bit w, input bit l,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        rq[i] = r; wq[i] = w; lq[i] = l; aq[i] = a; dq[i] = d;
        if (i == 0) begin
            bus.m0_req = r; bus.m0_we = w; bus.m0_lock = l; bus.m0_addr = a; bus.m0_wdata = d;
        end else begin
            bus.m1_req = r; bus.m1_we = w; bus.m1_lock = l; bus.m1_addr = a; bus.m1_wdata = d;
        end
    endtask

    task automatic cycle(output int dg, output int dwe);
        int g, gi;
        #3;
        if (reset) g = -1;
        else if (own >= 0 && rq[own]) g = own;
        else if (rq[0] && rq[1]) g = mlast ? 0 : 1;
        else if (rq[0]) g = 0;
        else if (rq[1]) g = 1;
        else g = -1;
        gi  = g < 0 ? 0 : g;
        dg  = bus.m1_gnt ? 1 : (bus.m0_gnt ? 0 : -1);
        dwe = int'(bus.ram_we);
        check("gnt0", bus.m0_gnt, g == 0);
        check("gnt1", bus.m1_gnt, g == 1);
        check("ram_we", bus.ram_we, g >= 0 && wq[gi]);
        check("ram_addr", bus.ram_addr, aq[gi]);
        check("ram_data", bus.ram_data, dq[gi]);
        check("rvalid0", bus.m0_rvalid, pv[0] && !reset);
        check("rvalid1", bus.m1_rvalid, pv[1] && !reset);
        check("rdata0", bus.m0_rdata, (pv[0] && !reset) ? pd[0] : '0);
        check("rdata1", bus.m1_rdata, (pv[1] && !reset) ? pd[1] : '0);
        if (reset) begin
            own = -1; cnt = 0; mlast = 1'b1; pv[0] = 0; pv[1] = 0;
        end else begin
            pv[0] = (g == 0) && !wq[0];
            pv[1] = (g == 1) && !wq[1];
            if (g >= 0) begin
                if (wq[g]) ref_mem[aq[g]] = dq[g];
                else pd[g] = ref_mem[aq[g]];
                mlast = (g == 1);
                if (own >= 0 && g == own) begin
                    cnt++;
                    if (!lq[g] || cnt == MB) own = -1;
                end else begin
                    own = (own < 0 && lq[g] && MB > 1) ? g : -1;
                    cnt = 1;
                end
            end else begin
                own = -1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    int dg, dwe, nwe;
    int bexp [6] = '{1, 1, 1, 1, 0, 1};
    int uexp [3] = '{1, 1, 0};
    logic [AW-1:0] baddr;

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            logic [DW-1:0] v;
            v = DW'($urandom);
            mem[i] = v;
            ref_mem[i] = v;
        end
        set_m(0, 1, 1, 0, 10'h001, 16'h1111);
        set_m(1, 1, 0, 1, 10'h002, 16'h2222);
        reset = 1'b1;
        @(posedge clk);
        #1;
        cycle(dg, dwe);
        cycle(dg, dwe);
        reset = 1'b0;
        set_m(0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0);
        cycle(dg, dwe);

        // Single read.
        mem[5] = 16'h1234;
        ref_mem[5] = 16'h1234;
        set_m(0, 1, 0, 0, 10'h005, 0);
        cycle(dg, dwe);
        check("single_gnt", dg, 0);
        set_m(0, 0, 0, 0, 0, 0);
        check("single_rvalid", bus.m0_rvalid, 1);
        check("single_rdata", bus.m0_rdata, 16'h1234);
        check("single_m1_rvalid", bus.m1_rvalid, 0);
        check("single_m1_rdata", bus.m1_rdata, 0);
        cycle(dg, dwe);

        // Contention straight after reset: m0 wins first, then alternate.
        reset = 1'b1;
        cycle(dg, dwe);
        reset = 1'b0;
        set_m(0, 1, 0, 0, 10'h010, 0);
        set_m(1, 1, 0, 0, 10'h020, 0);
        for (int k = 0; k < 4; k++) begin
            cycle(dg, dwe);
            check("cont_order", dg, k % 2);
            if (dg >= 0) set_m(dg, 1, 0, 0, aq[dg] + 1'b1, 0);
        end
        set_m(0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0);
        cycle(dg, dwe);

        // Locked burst of m1 while m0 waits.
        baddr = 10'h100;
        set_m(1, 1, 0, 1, baddr, 0);
        for (int k = 0; k < 6; k++) begin
            if (k == 1) set_m(0, 1, 0, 0, 10'h050, 0);
            cycle(dg, dwe);
            check("burst_order", dg, bexp[k]);
            if (dg == 1) begin
                baddr = baddr + 1'b1;
                set_m(1, 1, 0, 1, baddr, 0);
            end
            if (dg == 0) set_m(0, 0, 0, 0, 0, 0);
        end
        check("burst_addr_end", baddr, 10'h105);
        set_m(0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0);
        cycle(dg, dwe);

        // Lock dropped on m1's second grant.
        set_m(1, 1, 0, 1, 10'h200, 0);
        for (int k = 0; k < 3; k++) begin
            cycle(dg, dwe);
            check("unlock_order", dg, uexp[k]);
            if (k == 0) begin
                set_m(0, 1, 0, 0, 10'h060, 0);
                set_m(1, 1, 0, 0, 10'h201, 0);
            end
        end
        set_m(0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0);
        cycle(dg, dwe);

        // Write then read-back at the top address.
        nwe = 0;
        set_m(0, 1, 1, 0, 10'h3FF, 16'hBEEF);
        cycle(dg, dwe);
        nwe += dwe;
        set_m(0, 1, 0, 0, 10'h3FF, 0);
        check("wr_no_rvalid", bus.m0_rvalid, 0);
        cycle(dg, dwe);
        nwe += dwe;
        set_m(0, 0, 0, 0, 0, 0);
        check("rd_rvalid", bus.m0_rvalid, 1);
        check("rd_rdata", bus.m0_rdata, 16'hBEEF);
        cycle(dg, dwe);
        nwe += dwe;
        check("wr_we_count", nwe, 1);

        // Reset while a read is pending.
        set_m(0, 1, 0, 0, 10'h007, 0);
        cycle(dg, dwe);
        set_m(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        check("rst_rvalid", bus.m0_rvalid, 0);
        cycle(dg, dwe);
        reset = 1'b0;
        set_m(0, 1, 0, 0, 10'h008, 0);
        set_m(1, 1, 0, 0, 10'h009, 0);
        cycle(dg, dwe);
        check("rst_tie", dg, 0);

        // Random traffic; requests held until granted.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!rq[i] || dg == i) begin
                    set_m(i, $urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0,
                          $urandom_range(0, 2) == 0, AW'($urandom_range(0, 15)), DW'($urandom));
                end else if (lq[i] && $urandom_range(0, 5) == 0) begin
                    set_m(i, rq[i], wq[i], 0, aq[i], dq[i]);
                end
            end
            reset = ($urandom_range(0, 299) == 0);
            cycle(dg, dwe);
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
